// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict flag and saturating stats
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_pc,
    output logic        mispredict,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);
    localparam int N  = 1 << INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;
    logic            valid_q  [N];
    logic [TW-1:0]   tag_q    [N];
    logic [31:0]     target_q [N];
    logic [1:0]      ctr_q    [N];
    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic [TW-1:0]   f_tag, r_tag;
    logic            f_hit, r_hit;
    logic            unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], resolve_pc[1:0]};
    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign f_tag = fetch_pc[31:INDEX_BITS+2];
    assign r_idx = resolve_pc[INDEX_BITS+1:2];
    assign r_tag = resolve_pc[31:INDEX_BITS+2];
    assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
    assign r_hit = valid_q[r_idx] && tag_q[r_idx] == r_tag;
    assign pred_taken   = f_hit && ctr_q[f_idx][1];
    assign pred_next_pc = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    assign mispredict   = resolve_valid && (resolve_taken != resolve_pred_taken ||
                          resolve_pred_pc != (resolve_taken ? resolve_target : resolve_pc + 32'd4));
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (resolve_valid) begin
            branch_count     <= branch_count + {15'd0, branch_count != 16'hFFFF};
            mispredict_count <= mispredict_count + {15'd0, mispredict && mispredict_count != 16'hFFFF};
            if (r_hit) begin
                ctr_q[r_idx] <= resolve_taken ? (ctr_q[r_idx] == 2'b11 ? 2'b11 : ctr_q[r_idx] + 2'b01)
                                              : (ctr_q[r_idx] == 2'b00 ? 2'b00 : ctr_q[r_idx] - 2'b01);
                if (resolve_taken) target_q[r_idx] <= resolve_target;
            end else if (resolve_taken) begin
                valid_q[r_idx]  <= 1'b1;
                tag_q[r_idx]    <= r_tag;
                target_q[r_idx] <= resolve_target;
                ctr_q[r_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor paired with `branch_decider`: it predicts the direction and target of each fetched PC, and `branch_decider` later resolves the branch. The predictor holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. Each entry is trained from the resolved outcome (`branch_taken` plus the computed target) fed back from execute. It also flags mispredictions and keeps saturating statistics counters.

## Interface
- `INDEX_BITS`, default 4: BTB index width, giving 2^INDEX_BITS entries (default 16).
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; takes effect on a rising edge of `clk`.
- `fetch_pc`, input, 32: PC being fetched this cycle (word aligned).
- `pred_taken`, output, 1: predicted taken (combinational).
- `pred_next_pc`, output, 32: predicted next fetch PC (combinational).
- `resolve_valid`, input, 1: a branch resolved in execute this cycle.
- `resolve_pc`, input, 32: PC of the resolving branch.
- `resolve_taken`, input, 1: actual outcome (`branch_taken` from `branch_decider`).
- `resolve_target`, input, 32: actual taken target.
- `resolve_pred_taken`, input, 1: prediction carried down the pipe for this branch.
- `resolve_pred_pc`, input, 32: `pred_next_pc` carried down the pipe for this branch.
- `mispredict`, output, 1: resolved branch was mispredicted (combinational); drives the flush.
- `branch_count`, output, 16: resolved branches since reset, saturating.
- `mispredict_count`, output, 16: mispredictions since reset, saturating.

## Operation
- **Entry fields:** `valid`, `tag[29-INDEX_BITS:0]`, `target[31:0]`, `ctr[1:0]`.
- **Address split:**
  - index = `pc[INDEX_BITS+1:2]`
  - tag = `pc[31:INDEX_BITS+2]`
  - `pc[1:0]` is ignored.
- **Lookup (combinational):**
  - hit = `valid && tag match` at `fetch_pc`'s index.
  - `pred_taken` = `hit && ctr[1]`.
  - `pred_next_pc` = `pred_taken ? target : fetch_pc + 4`, with 32-bit wrap (0xFFFFFFFC + 4 = 0x00000000).
- **Mispredict (combinational):** `mispredict` = `resolve_valid && (resolve_taken != resolve_pred_taken || resolve_pred_pc != (resolve_taken ? resolve_target : resolve_pc + 4))`. Low whenever `resolve_valid` = 0.
- **Update on `resolve_valid`, hit at `resolve_pc`:**
  - `ctr` increments when taken, saturating at 2'b11.
  - `ctr` decrements when not taken, saturating at 2'b00.
  - When taken, `target` <= `resolve_target`.
- **Update on `resolve_valid`, miss at `resolve_pc`:**
  - Taken: allocate or overwrite the entry at that index with `valid`=1, new tag, `target` = `resolve_target`, `ctr` = 2'b10 (weakly taken).
  - Not taken: no table change.
- **Counter state sequence:** 00 strongly-not-taken ↔ 01 weakly-not ↔ 10 weakly-taken ↔ 11 strongly-taken. Each step moves one position per resolution; there are no jumps.
- **Statistics:**
  - `branch_count` increments on every `resolve_valid`.
  - `mispredict_count` increments when `mispredict` = 1.
  - Both hold at 16'hFFFF.

## Timing
- **Reset values:** all `valid` = 0, all `ctr` = 2'b01, all `tag`/`target` = 0, `branch_count` = 0, `mispredict_count` = 0.
- **Outputs with an empty table:**
  - `pred_taken` = 0 and `pred_next_pc` = `fetch_pc + 4` immediately after reset.
  - `mispredict` follows its inputs.
- **Latency:**
  - Lookup: 0 cycles.
  - Update: written at the rising edge that samples `resolve_valid`, and visible to lookups from the next cycle.
- **Same-cycle lookup and update to the same index:** lookup returns the pre-update entry (no bypass).
- **Reset asserted together with `resolve_valid`:** reset wins, and no table or counter update occurs.
- **Reset mid-operation:** all state is cleared on that edge, and in-flight resolutions in the same cycle are discarded.
- **Reset is synchronous:** it has no effect until the next rising edge of `clk`.
- **Index aliasing:** on a tag mismatch with `resolve_taken` = 1, the resident entry is replaced unconditionally.
- **Throughput:** one resolve per cycle is supported back-to-back, including repeated resolves to the same PC on consecutive cycles (each sees the previous cycle's write).

## Test plan
- **Reset, empty table:** reset, then `fetch_pc`=0x00000040 → `pred_taken`=0, `pred_next_pc`=0x00000044, both counts 0.
- **Allocate and train:** resolve pc=0x40 taken, target=0x100 → next cycle, fetch 0x40 gives `pred_taken`=1, `pred_next_pc`=0x100. Two not-taken resolves → `pred_taken`=0 (ctr=00). One taken resolve → still 0 (ctr=01).
- **Saturation:** five taken resolves on 0x40 leave ctr=11. One not-taken resolve → `pred_taken` still 1.
- **Mispredict detection:**
  - `resolve_pred_taken`=1, `resolve_pred_pc`=0x100, `resolve_taken`=1, `resolve_target`=0x200 → `mispredict`=1, `mispredict_count`+1.
  - Matching values → `mispredict`=0, `branch_count`+1 only.
- **Aliasing:** with INDEX_BITS=4, train 0x40 taken. Then resolve 0x440 taken to 0x300 → fetch 0x40 misses (`pred_next_pc`=0x44), fetch 0x440 predicts 0x300.
- **Reset priority:** assert `reset` with `resolve_valid`=1 (taken pc=0x80) → afterwards fetch 0x80 misses, counts 0. Also check PC wrap: fetch 0xFFFFFFFC with no entry → `pred_next_pc`=0x00000000.
